// File: rtl/viterbi_decoder_pkg.sv
// Shared constants, FSM state type and golden convolutional encoder helper
// for the K=4, rate-1/2 Viterbi decoder.
package viterbi_decoder_pkg;

  localparam int K        = 4;
  localparam int N_BITS   = 48;
  localparam int N_CODED  = 96;
  localparam int N_STATES = 8;

  localparam logic [7:0] PM_INIT = 8'd100;

  // Generator taps on {u, d_{k-1}, d_{k-2}, d_{k-3}}
  localparam logic [K-1:0] G1 = 4'b1011;
  localparam logic [K-1:0] G2 = 4'b1111;

  typedef enum logic [1:0] {IDLE, ACS, TRACE, DONE} state_e;

  // Coded pair {o1,o2} emitted for input u leaving trellis state s
  function automatic logic [1:0] enc_pair(input logic u, input logic [K-2:0] s);
    logic [K-1:0] r;
    r = {u, s};
    return {^(r & G1), ^(r & G2)};
  endfunction

endpackage

// File: rtl/viterbi_decoder_acs.sv
// Add-compare-select for one trellis state: two candidate sums, keep the
// smaller; on a tie the predecessor with LSB=0 wins.
module viterbi_acs (
  input  logic [7:0] pm0_i,
  input  logic [7:0] pm1_i,
  input  logic [1:0] bm0_i,
  input  logic [1:0] bm1_i,
  output logic [7:0] pm_o,
  output logic       dec_o
);

  logic [7:0] c0, c1;

  // Sums never exceed 196, so 8 bits cannot wrap
  always_comb begin
    c0    = pm0_i + {6'd0, bm0_i};
    c1    = pm1_i + {6'd0, bm1_i};
    dec_o = (c1 < c0);
    pm_o  = dec_o ? c1 : c0;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Block Viterbi decoder: 48 ACS cycles over the latched 96-bit block, then
// 48 traceback cycles through the survivor memory.
module viterbi_decoder
  import viterbi_decoder_pkg::*;
(
  input  logic               clck,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CODED-1:0] fec,
  output logic [N_BITS-1:0]  data_out,
  output logic               status,
  output logic               busy,
  output logic [6:0]         path_metric
);

  state_e state_q, state_d;

  logic [N_CODED-1:0]          fec_q;     // shifted left 2 per step; current pair at top
  logic [5:0]                  step_q;    // ACS step going up, traceback k going down
  logic [N_STATES-1:0][7:0]    pm_q;
  logic [N_STATES-1:0][7:0]    pm_new;
  logic [N_STATES-1:0]         dec;
  logic [2:0]                  cur_q;
  logic [N_BITS-2:0]           trace_q;
  logic [N_BITS-1:0]           data_q;
  logic                        status_q;
  logic [6:0]                  pm_out_q;
  logic [N_STATES-1:0]         surv_q [N_BITS];

  logic [1:0] rx;
  logic [2:0] best;
  logic [7:0] bpm;

  assign rx = fec_q[N_CODED-1 -: 2];

  // One ACS per next state n; predecessors are {n[1:0],0} and {n[1:0],1}
  for (genvar n = 0; n < N_STATES; n++) begin : g_acs
    localparam logic [2:0] NS = 3'(n);
    logic [1:0] x0, x1, bm0, bm1;
    assign x0  = rx ^ enc_pair(NS[2], {NS[1:0], 1'b0});
    assign x1  = rx ^ enc_pair(NS[2], {NS[1:0], 1'b1});
    assign bm0 = {x0[1] & x0[0], x0[1] ^ x0[0]};
    assign bm1 = {x1[1] & x1[0], x1[1] ^ x1[0]};
    viterbi_acs u_acs (
      .pm0_i (pm_q[{NS[1:0], 1'b0}]),
      .pm1_i (pm_q[{NS[1:0], 1'b1}]),
      .bm0_i (bm0),
      .bm1_i (bm1),
      .pm_o  (pm_new[n]),
      .dec_o (dec[n])
    );
  end

  // Best end state over the freshly computed metrics; ties to lowest index
  always_comb begin
    best = 3'd0;
    bpm  = pm_new[0];
    for (int i = 1; i < N_STATES; i++) begin
      if (pm_new[i] < bpm) begin
        best = 3'(i);
        bpm  = pm_new[i];
      end
    end
  end

  // State register
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start only matters in IDLE and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start)          state_d = ACS;
      ACS:        if (step_q == 6'd47) state_d = TRACE;
      TRACE:      if (step_q == 6'd0)  state_d = DONE;
      default:                        state_d = IDLE;
    endcase
  end

  // Datapath: metric update, traceback and result registers
  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      fec_q    <= '0;
      step_q   <= '0;
      pm_q     <= '0;
      cur_q    <= '0;
      trace_q  <= '0;
      data_q   <= '0;
      status_q <= 1'b0;
      pm_out_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          fec_q    <= fec;
          step_q   <= '0;
          pm_q     <= {{(N_STATES-1){PM_INIT}}, 8'd0};
          status_q <= 1'b0;
          data_q   <= '0;
          pm_out_q <= '0;
        end
        ACS: begin
          pm_q  <= pm_new;
          fec_q <= fec_q << 2;
          if (step_q == 6'd47) begin
            cur_q    <= best;
            pm_out_q <= bpm[6:0];
          end else begin
            step_q <= step_q + 6'd1;
          end
        end
        TRACE: begin
          cur_q   <= {cur_q[1:0], surv_q[step_q][cur_q]};
          trace_q <= {cur_q[2], trace_q[N_BITS-2:1]};
          if (step_q == 6'd0) begin
            data_q   <= {cur_q[2], trace_q};
            status_q <= 1'b1;
          end else begin
            step_q <= step_q - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Survivor decisions, one row per step; contents are don't-care after reset
  always_ff @(posedge clck) begin
    if (state_q == ACS) surv_q[step_q] <= dec;
  end

  assign busy        = (state_q == ACS) || (state_q == TRACE);
  assign status      = status_q;
  assign data_out    = data_q;
  assign path_metric = pm_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench for viterbi_decoder with an independent state-sequence
// Viterbi model and a cycle-level timing model checked every falling edge.
module tb_viterbi_decoder;

  logic        clck = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [95:0] fec = '0;
  logic [47:0] data_out;
  logic        status, busy;
  logic [6:0]  path_metric;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  viterbi_decoder dut (
    .clck        (clck),
    .rst_n       (rst_n),
    .start       (start),
    .fec         (fec),
    .data_out    (data_out),
    .status      (status),
    .busy        (busy),
    .path_metric (path_metric)
  );

  always #5 clck = ~clck;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  // Golden rate-1/2 encoder written straight from the tap equations
  function automatic logic [95:0] encode(input logic [47:0] d);
    logic [95:0] f;
    logic a, b, c, u;
    f = '0; a = 1'b0; b = 1'b0; c = 1'b0;
    for (int k = 0; k < 48; k++) begin
      u = d[47-k];
      f[95-2*k] = u ^ b ^ c;
      f[94-2*k] = u ^ a ^ b ^ c;
      c = b; b = a; a = u;
    end
    return f;
  endfunction

  // Reference decoder: forward pass records full predecessor states,
  // traceback walks states rather than decision bits.
  function automatic void viterbi(input logic [95:0] f, output logic [47:0] d, output int pm_o);
    int pm[8];
    int nx[8];
    int prv[48][8];
    int r1, r2, n, e1, e2, bm, c, st, best;
    for (int s = 0; s < 8; s++) pm[s] = (s == 0) ? 0 : 100;
    for (int k = 0; k < 48; k++) begin
      r1 = int'(f[95-2*k]);
      r2 = int'(f[94-2*k]);
      for (int s = 0; s < 8; s++) nx[s] = 100000;
      for (int s = 0; s < 8; s++) begin
        for (int u = 0; u < 2; u++) begin
          n  = u * 4 + s / 2;
          e1 = u ^ ((s >> 1) & 1) ^ (s & 1);
          e2 = u ^ ((s >> 2) & 1) ^ ((s >> 1) & 1) ^ (s & 1);
          bm = ((e1 != r1) ? 1 : 0) + ((e2 != r2) ? 1 : 0);
          c  = pm[s] + bm;
          if (c < nx[n]) begin
            nx[n] = c;
            prv[k][n] = s;
          end
        end
      end
      for (int s = 0; s < 8; s++) pm[s] = nx[s];
    end
    best = 0;
    for (int s = 1; s < 8; s++) if (pm[s] < pm[best]) best = s;
    pm_o = pm[best];
    st = best;
    d = '0;
    for (int k = 47; k >= 0; k--) begin
      d[47-k] = ((st >> 2) & 1) != 0;
      st = prv[k][st];
    end
  endfunction

  // Timing model: the accepted start edge counts as cycle 1, result at cycle 97
  bit          m_busy = 1'b0, m_status = 1'b0;
  logic [47:0] m_data = '0, m_data_nx = '0;
  int          m_pm = 0, m_pm_nx = 0, m_cnt = 0;

  always @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_status = 1'b0; m_data = '0; m_pm = 0; m_cnt = 0;
    end else if (start && !m_busy) begin
      m_busy = 1'b1; m_status = 1'b0; m_cnt = 1;
      viterbi(fec, m_data_nx, m_pm_nx);
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 97) begin
        m_busy = 1'b0; m_status = 1'b1; m_data = m_data_nx; m_pm = m_pm_nx;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clck) begin
    if (chk_on) begin
      chk("busy", 96'(busy), 96'(m_busy));
      chk("status", 96'(status), 96'(m_status));
      if (!m_busy) begin
        chk("data_out", 96'(data_out), 96'(m_data));
        chk("path_metric", 96'(path_metric), 96'(m_pm));
      end
    end
  end

  // Start a decode, optionally poke start again at cycle intr_at, wait for status
  task automatic run_decode(input logic [95:0] f, input int intr_at, output int lat);
    @(posedge clck); #2; fec = f; start = 1'b1;
    @(posedge clck); #2; start = 1'b0; fec = ~f; lat = 1;
    while (!status && lat < 300) begin
      @(posedge clck); #2;
      lat++;
      if (lat == intr_at) begin start = 1'b1; fec = '0; end
      else start = 1'b0;
    end
    start = 1'b0;
  endtask

  localparam logic [47:0] DATA = 48'hA5A5_F00F_1234;
  logic [95:0] clean, m1, m2;
  logic [7:0]  top;
  int lat;

  initial begin
    clean = encode(DATA);
    m1 = '0; m1[60] = 1'b1;
    m2 = '0; m2[90] = 1'b1; m2[20] = 1'b1;

    repeat (3) @(posedge clck);
    chk_on = 1'b1;
    @(negedge clck);
    chk("rst busy", 96'(busy), 96'd0);
    chk("rst status", 96'(status), 96'd0);
    chk("rst data_out", 96'(data_out), 96'd0);
    chk("rst path_metric", 96'(path_metric), 96'd0);
    @(posedge clck); #2; rst_n = 1'b1;

    // Encoder pin: A5.. begins 1,0,1,0 -> pairs 11 01 00 10
    top = clean[95:88];
    chk("enc top byte", 96'(top), 96'hD2);

    run_decode('0, 0, lat);
    chk("zero latency", 96'(lat), 96'd97);
    chk("zero data", 96'(data_out), 96'd0);
    chk("zero pm", 96'(path_metric), 96'd0);

    run_decode(clean, 0, lat);
    chk("clean latency", 96'(lat), 96'd97);
    chk("clean data", 96'(data_out), 96'(DATA));
    chk("clean pm", 96'(path_metric), 96'd0);

    run_decode(clean ^ m1, 0, lat);
    chk("bit60 data", 96'(data_out), 96'(DATA));
    chk("bit60 pm", 96'(path_metric), 96'd1);

    run_decode(clean ^ m2, 0, lat);
    chk("bits90_20 data", 96'(data_out), 96'(DATA));
    chk("bits90_20 pm", 96'(path_metric), 96'd2);

    // Reset while ACS is on step 20
    @(posedge clck); #2; fec = clean; start = 1'b1;
    @(posedge clck); #2; start = 1'b0;
    repeat (20) @(posedge clck);
    #2; rst_n = 1'b0;
    @(negedge clck);
    chk("abort busy", 96'(busy), 96'd0);
    chk("abort status", 96'(status), 96'd0);
    chk("abort data_out", 96'(data_out), 96'd0);
    chk("abort path_metric", 96'(path_metric), 96'd0);
    @(posedge clck); #2; rst_n = 1'b1;
    run_decode(clean ^ m1, 0, lat);
    chk("post-abort latency", 96'(lat), 96'd97);
    chk("post-abort data", 96'(data_out), 96'(DATA));
    chk("post-abort pm", 96'(path_metric), 96'd1);

    // Second start during traceback must be ignored
    run_decode(clean, 60, lat);
    chk("retrigger latency", 96'(lat), 96'd97);
    chk("retrigger data", 96'(data_out), 96'(DATA));
    chk("retrigger pm", 96'(path_metric), 96'd0);

    repeat (3) @(posedge clck);
    @(negedge clck);
    chk("hold data", 96'(data_out), 96'(DATA));
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
